down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Loadable down-counting timer; the counting counterpart to the team's free-running 4-bit up counter.
- Software or an FSM loads a terminal value, starts the timer, and receives a one-cycle terminal-count pulse.
- Supports one-shot and periodic (auto-reload) modes, pause/resume, and abort.
- Used as a timeout and periodic-tick source alongside the up counter.

Parameters:
- WIDTH, 4, counter and load-value width in bits (>=2).
- PRESCALE, 4, clock cycles per count tick; honoured only when DOWN_TIMER_PRESCALE_EN is defined (>=1).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- load  input  1  load load_val into count and the reload register.
- load_val  input  WIDTH  value captured on load.
- start  input  1  begin counting, or resume from HOLD.
- pause  input  1  freeze counting while RUN.
- abort  input  1  return to IDLE and clear count.
- periodic  input  1  1 = auto-reload, 0 = one-shot; sampled every tick.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high while in RUN.
- tc  output  1  one-cycle terminal-count pulse (registered).
- done  output  1  sticky one-shot completion flag.

Behaviour:
- Reset: reset==0 at a posedge forces:
  - state=IDLE; count=0; reload=0; tc=0; done=0; prescaler=0.
  - Reset overrides every other input and aborts any operation in progress.
- States: IDLE, RUN, HOLD. busy = (state==RUN).
- Input priority, highest first: reset, abort, load, start, pause.
- abort (any state): next state IDLE; count=0; done=0; tc=0; reload kept.
- load:
  - Accepted in IDLE and HOLD only; ignored in RUN.
  - Sets count=load_val, reload=load_val, done=0.
- start:
  - In IDLE or HOLD with effective count != 0: next state RUN.
  - Effective count is load_val if load is asserted the same cycle, otherwise count. So load plus start in one cycle gives RUN with count=load_val on the next cycle.
  - start with effective count 0 is ignored; state is unchanged.
  - start in IDLE clears done.
- pause: in RUN, next state HOLD, count frozen. Ignored in IDLE and HOLD.
- Count tick: every RUN cycle (prescale variant below); no counting in IDLE or HOLD.
- On a tick with count > 1: count decrements by 1.
- On a tick with count == 1:
  - tc=1 for exactly the next cycle.
  - periodic=1: count=reload; state stays RUN.
  - periodic=0: count=0; state goes to IDLE; done=1.
- Latency: after load N and start, tc is high on the Nth tick edge. In periodic mode tc repeats every N ticks.
- Wrap-around: count never wraps below 0. Unsigned arithmetic, WIDTH bits. load_val 0 is legal but cannot be started.
- Mid-count load: HOLD → load → start resumes from the new value. The old remainder is discarded.
- tc is 0 in every cycle not described above. done is cleared only by load, start-from-IDLE, abort, or reset.

Optional Feature:
- Macro: DOWN_TIMER_PRESCALE_EN.
- Defined:
  - A prescaler (ceil(log2(PRESCALE)) bits) counts clk cycles in RUN only. A tick occurs when it reaches PRESCALE-1, then it wraps to 0.
  - The prescaler is cleared on reset, abort, load, and the start that enters RUN. It holds its value in HOLD.
  - Period per count = PRESCALE clk cycles.
- Undefined: no prescaler logic; every RUN cycle is a tick; PRESCALE is ignored.

Test Plan:
- Reset: reset=0 for 2 cycles during RUN → count=0, busy=0, tc=0, done=0 on the first posedge of reset.
- One-shot, WIDTH=4: load_val=5 + load + start in one cycle, periodic=0 → count 5,4,3,2,1,0 on successive cycles; tc high one cycle as count reaches 0; busy falls, done=1 and stays until the next load.
- Periodic: load 3, periodic=1, start, run 10 cycles → count 3,2,1,3,2,1,…; tc pulses every 3 cycles; busy stays high; done stays 0.
- Pause/resume: load 6, start, pause at count 4 for 5 cycles → count holds 4, busy=0; start → resumes 3,2,1,0 with tc once. load and start issued in RUN are ignored.
- Boundaries:
  - load 0 + start → stays IDLE, no tc.
  - load 15 (max), one-shot → tc after exactly 15 ticks.
  - abort at count 7 → count=0, IDLE, no tc.
- Prescale (macro defined, PRESCALE=4): load 2, start → count 2 for 4 cycles, 1 for 4 cycles, then 0 with tc. Pause mid-period then resume → the remaining prescale cycles are preserved.

Source files
------------

// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// DownTimer (module down_timer)
// Loadable down-counting timer with one-shot and periodic (auto-reload)
// modes, pause/resume and abort. Produces a registered one-cycle
// terminal-count pulse and a sticky one-shot completion flag.
//
// Ports:
//   clk       in   1      clock, all logic on the rising edge
//   reset     in   1      synchronous active-low reset
//   load      in   1      capture load_val into count and reload (IDLE/HOLD)
//   load_val  in   WIDTH  value captured on load
//   start     in   1      begin counting from IDLE, or resume from HOLD
//   pause     in   1      freeze counting while running
//   abort     in   1      return to IDLE and clear count (reload kept)
//   periodic  in   1      1 = auto-reload at terminal count, 0 = one-shot
//   count     out  WIDTH  current count value (registered)
//   busy      out  1      high while running
//   tc        out  1      one-cycle terminal-count pulse (registered)
//   done      out  1      sticky one-shot completion flag
//
// Optional feature macro: DOWN_TIMER_PRESCALE_EN
//   Defined   : a prescaler divides RUN cycles so one count tick occurs every
//               PRESCALE clock cycles.
//   Undefined : every RUN cycle is a count tick and PRESCALE is unused.
// ---------------------------------------------------------------------------
module down_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_done;

  logic [1:0]       w_nextState;
  logic [WIDTH-1:0] w_nextCount;
  logic [WIDTH-1:0] w_nextReload;
  logic             w_nextTc;
  logic             w_nextDone;
  logic [WIDTH-1:0] w_effCount;
  logic             w_tick;

  // A same-cycle load decides whether a start is allowed, so start looks at
  // the value that is about to be loaded rather than the stale count.
  assign w_effCount = load ? load_val : r_count;

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_pre;
  logic          w_preClear;
  logic          w_preAdvance;

  // The prescaler restarts a full period whenever a fresh count begins
  // (abort, accepted load, start out of IDLE). Resuming from HOLD does not
  // clear it, so a pause keeps the partially elapsed period.
  assign w_preClear   = abort
                      | ((r_state != RUN) & load)
                      | ((r_state == IDLE) & start & (w_effCount != '0));
  assign w_preAdvance = (r_state == RUN) & ~abort & ~pause;
  assign w_tick       = (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (w_preClear) begin
      r_pre <= '0;
    end else if (w_preAdvance) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end
`else
  logic w_unusedPrescale;

  assign w_unusedPrescale = (PRESCALE >= 1);
  assign w_tick           = 1'b1;
`endif

  // Next-state logic. Priority is abort, then load, then start, then pause;
  // load and start have no effect while running, so in RUN only pause or a
  // count tick can change anything.
  always_comb begin
    w_nextState  = r_state;
    w_nextCount  = r_count;
    w_nextReload = r_reload;
    w_nextTc     = 1'b0;
    w_nextDone   = r_done;

    if (abort) begin
      w_nextState = IDLE;
      w_nextCount = '0;
      w_nextDone  = 1'b0;
    end else if (r_state != RUN) begin
      if (load) begin
        w_nextCount  = load_val;
        w_nextReload = load_val;
        w_nextDone   = 1'b0;
      end
      if (start && (w_effCount != '0)) begin
        w_nextState = RUN;
        if (r_state == IDLE) begin
          w_nextDone = 1'b0;
        end
      end
    end else if (pause) begin
      w_nextState = HOLD;
    end else if (w_tick) begin
      if (r_count > WIDTH'(1)) begin
        w_nextCount = r_count - WIDTH'(1);
      end else if (r_count == WIDTH'(1)) begin
        w_nextTc = 1'b1;
        if (periodic) begin
          w_nextCount = r_reload;
        end else begin
          w_nextCount = '0;
          w_nextState = IDLE;
          w_nextDone  = 1'b1;
        end
      end else begin
        // A zero count cannot be started, so this is only a safety exit.
        w_nextState = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_count  <= w_nextCount;
      r_reload <= w_nextReload;
      r_tc     <= w_nextTc;
      r_done   <= w_nextDone;
    end
  end

  assign count = r_count;
  assign busy  = (r_state == RUN);
  assign tc    = r_tc;
  assign done  = r_done;

endmodule

// File: tb/tb_down_timer.sv
// ---------------------------------------------------------------------------
// TbDownTimer (module tb_down_timer)
// Directed testbench for down_timer (WIDTH=4, PRESCALE=4) with hand-computed
// expectations. The prescaler scenario is only exercised when
// DOWN_TIMER_PRESCALE_EN is defined.
// ---------------------------------------------------------------------------
module tb_down_timer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       loadIn;
  logic [3:0] loadVal;
  logic       startIn;
  logic       pauseIn;
  logic       abortIn;
  logic       periodicIn;
  logic [3:0] countOut;
  logic       busyOut;
  logic       tcOut;
  logic       doneOut;

  int total = 0;
  int bad   = 0;

  down_timer #(.WIDTH(4), .PRESCALE(4)) dut (
    .clk      (clk),
    .reset    (resetN),
    .load     (loadIn),
    .load_val (loadVal),
    .start    (startIn),
    .pause    (pauseIn),
    .abort    (abortIn),
    .periodic (periodicIn),
    .count    (countOut),
    .busy     (busyOut),
    .tc       (tcOut),
    .done     (doneOut)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int expCount, input int expBusy,
                          input int expTc, input int expDone);
    checkOutput({tag, ".count"}, int'(countOut), expCount);
    checkOutput({tag, ".busy"},  int'(busyOut),  expBusy);
    checkOutput({tag, ".tc"},    int'(tcOut),    expTc);
    checkOutput({tag, ".done"},  int'(doneOut),  expDone);
  endtask

  // Drives one cycle of inputs, then waits past the next rising edge so the
  // registered outputs are sampled away from the edge.
  task automatic applyStimulus(input logic ld, input logic [3:0] val, input logic st,
                               input logic pa, input logic ab);
    loadIn  = ld;
    loadVal = val;
    startIn = st;
    pauseIn = pa;
    abortIn = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetN     = 1'b0;
    periodicIn = 1'b0;
    loadIn     = 1'b0;
    loadVal    = 4'd0;
    startIn    = 1'b0;
    pauseIn    = 1'b0;
    abortIn    = 1'b0;

    // Power-on reset.
    idleCycle();
    idleCycle();
    checkAll("rst0", 0, 0, 0, 0);
    resetN = 1'b1;

    // One-shot: load 5 and start together.
    $display("[TB] one-shot 5");
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    checkAll("os.first", 5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      idleCycle();
      checkAll("os.run", i, 1, 0, 0);
    end
    idleCycle();
    checkAll("os.tc", 0, 0, 1, 1);
    idleCycle();
    checkAll("os.after", 0, 0, 0, 1);
    idleCycle();
    checkAll("os.sticky", 0, 0, 0, 1);

    // Load clears done; then reset in the middle of a run.
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    checkAll("ld9", 9, 0, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkAll("st9", 9, 1, 0, 0);
    idleCycle();
    checkAll("run8", 8, 1, 0, 0);
    resetN = 1'b0;
    idleCycle();
    checkAll("rstRun1", 0, 0, 0, 0);
    idleCycle();
    checkAll("rstRun2", 0, 0, 0, 0);
    resetN = 1'b1;

    // Periodic reload of 3, then drop periodic to finish as one-shot.
    $display("[TB] periodic 3");
    periodicIn = 1'b1;
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    checkAll("per.first", 3, 1, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      idleCycle();
      checkAll("per.run", (k % 3 == 0) ? 3 : 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0, 0);
    end
    periodicIn = 1'b0;
    idleCycle();
    checkAll("per.stop1", 1, 1, 0, 0);
    idleCycle();
    checkAll("per.stop0", 0, 0, 1, 1);

    // Pause/resume; load and start while running are ignored.
    $display("[TB] pause/resume");
    applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    checkAll("pr.first", 6, 1, 0, 0);
    idleCycle();
    checkAll("pr.5", 5, 1, 0, 0);
    applyStimulus(1'b1, 4'd12, 1'b1, 1'b0, 1'b0);
    checkAll("pr.ignLdSt", 4, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkAll("pr.hold", 4, 0, 0, 0);
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkAll("pr.resume", 4, 1, 0, 0);
    for (int i = 3; i >= 1; i--) begin
      idleCycle();
      checkAll("pr.run", i, 1, 0, 0);
    end
    idleCycle();
    checkAll("pr.tc", 0, 0, 1, 1);

    // Zero load cannot be started.
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    checkAll("zero.st", 0, 0, 0, 0);
    idleCycle();
    checkAll("zero.idle", 0, 0, 0, 0);

    // Maximum load: terminal count after exactly 15 ticks.
    $display("[TB] max load 15");
    applyStimulus(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    checkAll("max.first", 15, 1, 0, 0);
    for (int i = 14; i >= 1; i--) begin
      idleCycle();
      checkAll("max.run", i, 1, 0, 0);
    end
    idleCycle();
    checkAll("max.tc", 0, 0, 1, 1);

    // Abort in IDLE clears the sticky done flag.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkAll("abIdle", 0, 0, 0, 0);

    // Abort at count 7, then a bare start on zero count is ignored.
    applyStimulus(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    checkAll("ab.first", 9, 1, 0, 0);
    idleCycle();
    idleCycle();
    checkAll("ab.7", 7, 1, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkAll("ab.abort", 0, 0, 0, 0);
    idleCycle();
    checkAll("ab.noTc", 0, 0, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkAll("ab.stZero", 0, 0, 0, 0);

    // Load while held replaces the remainder.
    $display("[TB] mid-count load");
    applyStimulus(1'b1, 4'd10, 1'b1, 1'b0, 1'b0);
    idleCycle();
    checkAll("mid.9", 9, 1, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkAll("mid.hold", 9, 0, 0, 0);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    checkAll("mid.ld3", 3, 0, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkAll("mid.resume", 3, 1, 0, 0);
    idleCycle();
    idleCycle();
    checkAll("mid.1", 1, 1, 0, 0);
    idleCycle();
    checkAll("mid.tc", 0, 0, 1, 1);

`ifdef DOWN_TIMER_PRESCALE_EN
    // Prescale of 4: each count value lasts four cycles; a pause keeps the
    // partially elapsed period.
    $display("[TB] prescale 4");
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    checkAll("ps.first", 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkAll("ps.hold2", 2, 1, 0, 0);
    end
    idleCycle();
    checkAll("ps.1", 1, 1, 0, 0);
    idleCycle();
    idleCycle();
    checkAll("ps.mid", 1, 1, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkAll("ps.pause", 1, 0, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkAll("ps.pause2", 1, 0, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkAll("ps.resume", 1, 1, 0, 0);
    idleCycle();
    checkAll("ps.last", 1, 1, 0, 0);
    idleCycle();
    checkAll("ps.tc", 0, 0, 1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
